// File: rtl/cbus_rx_sync.sv
// Multi-lane 8b10b receive synchroniser: per-lane comma acquisition and
// error-budget loss-of-sync tracking with gated, registered data forwarding.
module cbus_rx_sync #(
  parameter int unsigned LANES    = 1,
  parameter int unsigned ACQ_CNT  = 3,
  parameter int unsigned ERR_MAX  = 4,
  parameter int unsigned GOOD_CNT = 4,
  parameter logic [7:0]  COMMA    = 8'hBC
) (
  input  logic               pcs_rxclk,
  input  logic               pcs_rxrst_n,
  input  logic [8*LANES-1:0] in_data,
  input  logic [LANES-1:0]   in_charisk,
  input  logic [LANES-1:0]   in_disperr,
  input  logic [LANES-1:0]   in_notintable,
  input  logic               in_valid,
  input  logic [LANES-1:0]   sticky_clr,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_charisk,
  output logic               out_valid,
  output logic [LANES-1:0]   lane_sync,
  output logic               all_sync,
  output logic [LANES-1:0]   sticky_los
);

  typedef enum logic [1:0] {StLoss, StAcq, StSync} state_e;

  localparam logic [3:0] AcqMax  = 4'(ACQ_CNT);
  localparam logic [3:0] ErrMax  = 4'(ERR_MAX);
  localparam logic [3:0] GoodMax = 4'(GOOD_CNT);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Reset release synchroniser; assertion stays asynchronous.
  logic [1:0] rst_sync_q;
  always_ff @(posedge pcs_rxclk or negedge pcs_rxrst_n) begin
    if (!pcs_rxrst_n) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // FSMs only advance once reset release has propagated and input is qualified.
  logic upd;
  assign upd = rst_sync_q[1] & in_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_e     state_q, state_d;
    logic [3:0] acq_q, acq_d, err_q, err_d, good_q, good_d;
    logic       los_evt;
    logic [7:0] data_q;
    logic       k_q, sticky_q;
    logic       bad, comma;

    assign bad   = in_disperr[i] | in_notintable[i];
    assign comma = in_charisk[i] & (in_data[8*i +: 8] == COMMA) & ~bad;

    // Next-state and counter update for the character presented this cycle.
    always_comb begin
      state_d = state_q;
      acq_d   = acq_q;
      err_d   = err_q;
      good_d  = good_q;
      los_evt = 1'b0;
      unique case (state_q)
        StLoss: begin
          if (comma) begin
            if (AcqMax <= 4'd1) begin
              state_d = StSync;
              acq_d   = 4'd0;
              err_d   = 4'd0;
              good_d  = 4'd0;
            end else begin
              state_d = StAcq;
              acq_d   = 4'd1;
            end
          end
        end
        StAcq: begin
          if (bad) begin
            state_d = StLoss;
            acq_d   = 4'd0;
            err_d   = 4'd0;
            good_d  = 4'd0;
          end else if (comma) begin
            acq_d = sat_inc(acq_q);
            if (acq_d >= AcqMax) begin
              state_d = StSync;
              err_d   = 4'd0;
              good_d  = 4'd0;
            end
          end
        end
        StSync: begin
          if (bad) begin
            err_d  = sat_inc(err_q);
            good_d = 4'd0;
            if (err_d >= ErrMax) begin
              state_d = StLoss;
              acq_d   = 4'd0;
              err_d   = 4'd0;
              good_d  = 4'd0;
              los_evt = 1'b1;
            end
          end else begin
            good_d = sat_inc(good_q);
            if (good_d >= GoodMax) begin
              good_d = 4'd0;
              err_d  = (err_q != 4'd0) ? err_q - 4'd1 : 4'd0;
            end
          end
        end
        default: state_d = StLoss;
      endcase
    end

    // Lane state, counters, gated output data and sticky loss flag.
    always_ff @(posedge pcs_rxclk or negedge pcs_rxrst_n) begin
      if (!pcs_rxrst_n) begin
        state_q  <= StLoss;
        acq_q    <= 4'd0;
        err_q    <= 4'd0;
        good_q   <= 4'd0;
        data_q   <= 8'd0;
        k_q      <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        if (upd) begin
          state_q <= state_d;
          acq_q   <= acq_d;
          err_q   <= err_d;
          good_q  <= good_d;
          // Gate on post-update state: accepting comma passes, losing char is blanked.
          data_q  <= (state_d == StSync) ? in_data[8*i +: 8] : 8'd0;
          k_q     <= (state_d == StSync) ? in_charisk[i] : 1'b0;
        end
        if (upd && los_evt) sticky_q <= 1'b1;
        else if (sticky_clr[i]) sticky_q <= 1'b0;
      end
    end

    assign out_data[8*i +: 8] = data_q;
    assign out_charisk[i]     = k_q;
    assign lane_sync[i]       = (state_q == StSync);
    assign sticky_los[i]      = sticky_q;
  end

  // Common qualifier and aggregate sync flag.
  always_ff @(posedge pcs_rxclk or negedge pcs_rxrst_n) begin
    if (!pcs_rxrst_n) begin
      out_valid <= 1'b0;
      all_sync  <= 1'b0;
    end else begin
      out_valid <= upd;
      all_sync  <= &lane_sync;
    end
  end

endmodule

// File: doc/cbus_rx_sync.md
CBUS_RX_SYNC -- requirements
Module: cbus_rx_sync

Interface
REQ-001 Parameter LANES, default 1: number of independent decoded 8b10b lanes, range 1..8.
REQ-002 Parameter ACQ_CNT, default 3: consecutive clean commas needed to declare sync, range 1..15.
REQ-003 Parameter ERR_MAX, default 4: outstanding code errors that cause loss of sync, range 1..15.
REQ-004 Parameter GOOD_CNT, default 4: consecutive clean characters that retire one outstanding error, range 1..15.
REQ-005 Parameter COMMA, default 8'hBC: comma character value, valid only with charisk=1.
REQ-006 pcs_rxclk  in  1  single clock; all logic rising-edge.
REQ-007 pcs_rxrst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 in_data  in  8*LANES  decoded byte, lane n at [8n+7:8n].
REQ-009 in_charisk  in  LANES  control-character flag per lane.
REQ-010 in_disperr  in  LANES  disparity error per lane.
REQ-011 in_notintable  in  LANES  code error per lane.
REQ-012 in_valid  in  1  common qualifier; when 0, all lane inputs are ignored.
REQ-013 sticky_clr  in  LANES  per-lane clear of sticky_los.
REQ-014 out_data  out  8*LANES  registered data, forced 0 on unsynced lanes.
REQ-015 out_charisk  out  LANES  registered charisk, forced 0 on unsynced lanes.
REQ-016 out_valid  out  1  registered in_valid.
REQ-017 lane_sync  out  LANES  1 while lane FSM is in SYNC.
REQ-018 all_sync  out  1  registered AND of lane_sync.
REQ-019 sticky_los  out  LANES  set on any SYNC->LOSS transition, held until cleared.

Function
REQ-020 Each lane SHALL run an independent FSM with states LOSS, ACQ, SYNC; the FSM advances only on cycles with in_valid=1.
REQ-021 A character is "bad" when disperr|notintable=1, "comma" when charisk=1, data=COMMA and not bad, and "clean" otherwise when not bad.
REQ-022 LOSS: comma -> ACQ with acq counter=1; a bad or non-comma character keeps LOSS; if ACQ_CNT=1 a comma goes directly to SYNC.
REQ-023 ACQ: comma increments acq counter; reaching ACQ_CNT -> SYNC; clean non-comma holds the counter; bad -> LOSS, counter cleared.
REQ-024 SYNC: bad increments err counter and clears good counter; clean or comma increments good counter; good reaching GOOD_CNT decrements err (floor 0) and clears good.
REQ-025 SYNC: err counter reaching ERR_MAX -> LOSS; err, good and acq counters cleared on entry to LOSS.
REQ-026 Entry to SYNC SHALL clear err and good counters.
REQ-027 Counters SHALL be 4 bits, saturating and never wrapping.
REQ-028 out_data/out_charisk/out_valid SHALL have exactly 1 cycle latency from inputs; gating SHALL use lane_sync state after the current character is applied (the first comma accepted into SYNC is forwarded; the character causing LOSS is suppressed).
REQ-029 lane_sync SHALL be a registered state decode with no combinational input path; all_sync SHALL lag lane_sync by 1 cycle.
REQ-030 sticky_los set and sticky_clr in the same cycle: set wins.
REQ-031 in_valid=0 SHALL freeze all FSMs and counters and drive out_valid=0 next cycle; out_data holds its previous value.

Reset
REQ-032 pcs_rxrst_n=0 SHALL asynchronously force all lanes to LOSS, all counters to 0, out_data=0, out_charisk=0, out_valid=0, lane_sync=0, all_sync=0, sticky_los=0.
REQ-033 Reset deassertion SHALL be synchronised internally to pcs_rxclk (2-flop); the first FSM update occurs no earlier than the 2nd rising edge after release.
REQ-034 Reset asserted mid-acquisition or mid-SYNC SHALL discard in-progress counts; no sticky_los is raised by reset.

Verification
REQ-035 LANES=2, defaults; lane0 receives K28.5 x3 then D0.0 -> lane_sync[0]=1 after 3rd comma, out_data[7:0]=8'hBC on that cycle+1; lane1 idle -> all_sync=0.
REQ-036 Lane in SYNC; 4 notintable characters separated by 3 clean characters -> err reaches 4, LOSS, sticky_los=1, out_data forced 0.
REQ-037 Lane in SYNC; pattern (1 bad, 4 clean) repeated 20 times -> err oscillates 1/0, lane_sync stays 1.
REQ-038 Lane in ACQ after 2 commas; in_valid=0 for 10 cycles, then a disperr character -> LOSS, out_valid=0 during gap.
REQ-039 sticky_clr pulse coincident with SYNC->LOSS event -> sticky_los remains 1; a later clear alone -> 0.
REQ-040 pcs_rxrst_n pulsed low mid-SYNC between clock edges -> all outputs 0 immediately, resync requires 3 new commas.
